// File: rtl/char_append.sv
// char_append: edge-triggered append of segment codes into an 8-slot display buffer.
// Newest character enters at the low slot; older characters shift toward the top.
module char_append #(
    parameter int SLOTS     = 8,
    parameter int CHAR_W    = 8,
    parameter int OVERWRITE = 1,
    localparam int CW       = $clog2(SLOTS + 1),
    localparam int BW       = SLOTS * CHAR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              char_valid,
    input  logic [CHAR_W-1:0] char_in,
    input  logic              clear,
    output logic [BW-1:0]     seg_out,
    output logic [CW-1:0]     count,
    output logic              full,
    output logic              empty,
    output logic              accept,
    output logic              drop
);
    logic              r_vld;
    logic [BW-1:0]     r_seg;
    logic [CW-1:0]     r_cnt;
    logic              r_acc;
    logic              r_drp;
    logic              w_evt;
    logic              w_full;
    logic [BW-1:0]     w_shift;

    assign w_evt   = char_valid & ~r_vld;
    assign w_full  = r_cnt == CW'(SLOTS);
    assign w_shift = {r_seg[BW-CHAR_W-1:0], char_in};

    // r_vld resets high so a strobe held across reset release is not an edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vld <= 1'b1;
            r_seg <= '0;
            r_cnt <= '0;
            r_acc <= 1'b0;
            r_drp <= 1'b0;
        end else begin
            r_vld <= char_valid;
            r_acc <= 1'b0;
            r_drp <= 1'b0;
            if (clear) begin
                r_seg <= '0;
                r_cnt <= '0;
            end else if (w_evt) begin
                if (char_in == '0) begin
                    r_drp <= 1'b1;
                end else if (!w_full) begin
                    r_seg <= w_shift;
                    r_cnt <= r_cnt + 1'b1;
                    r_acc <= 1'b1;
                end else if (OVERWRITE != 0) begin
                    r_seg <= w_shift;
                    r_acc <= 1'b1;
                    r_drp <= 1'b1;
                end else begin
                    r_drp <= 1'b1;
                end
            end
        end
    end

    assign seg_out = r_seg;
    assign count   = r_cnt;
    assign full    = w_full;
    assign empty   = r_cnt == '0;
    assign accept  = r_acc;
    assign drop    = r_drp;
endmodule

// File: doc/char_append.md
Name: char_append

Overview:
- Write-side counterpart of the display buffer's backspace path. Appends one decoded 8-bit segment code to a 64-bit, 8-slot display buffer.
- The newest character sits in bits [7:0]. Older characters shift toward [63:56].
- Sits between the Morse symbol decoder and the seven-segment scanner. Its buffer output feeds the backspace stage and the display.
- A slot value of 8'h00 means "empty". It is never stored as a character.

Parameters:
SLOTS, 8, number of character slots in the buffer
CHAR_W, 8, width of one segment code in bits
OVERWRITE, 1, 1 = when full, drop the oldest char and accept the new one; 0 = when full, reject the new char

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous active-low reset
char_valid  input  1  level strobe from decoder; may be held high for many cycles
char_in  input  CHAR_W  segment code of the decoded character; sampled when the append fires
clear  input  1  synchronous clear of the whole buffer
seg_out  output  SLOTS*CHAR_W  display buffer (64 bits default); slot 0 = [7:0] = newest
count  output  clog2(SLOTS+1)  number of occupied slots, 0..SLOTS (4 bits default)
full  output  1  count == SLOTS
empty  output  1  count == 0
accept  output  1  one-cycle pulse: a char was written
drop  output  1  one-cycle pulse: a char was rejected, or the oldest char was discarded

Behaviour:
- Reset (rst low, asynchronous): seg_out=0, count=0, accept=0, drop=0, and the internal edge register vld_q=1.
  - With vld_q=1, a char_valid held high across reset release does not append.
- full and empty are combinational from count. After reset: empty=1, full=0.
- Edge detect: vld_q <= char_valid every cycle. An event fires when char_valid=1 and vld_q=0.
  - A held strobe yields exactly one event.
  - A new event needs char_valid low for at least 1 cycle.
- Latency: on the rising edge that samples the event, seg_out, count, accept and drop all update together. The pulses are high for exactly 1 cycle.
- Priority per cycle: clear > event > hold.
  - clear=1: seg_out=0, count=0, accept=0, drop=0. A simultaneous event is discarded with no drop pulse. vld_q still updates, so the strobe must be released before it can fire again.
  - Event with char_in == 0: buffer unchanged, drop=1, accept=0.
  - Event with count < SLOTS: seg_out <= {seg_out[SLOTS*CHAR_W-CHAR_W-1:0], char_in}; count+1; accept=1.
  - Event with count == SLOTS and OVERWRITE=1: same shift, so slot SLOTS-1 is lost; count stays SLOTS; accept=1 and drop=1.
  - Event with count == SLOTS and OVERWRITE=0: buffer unchanged; accept=0, drop=1.
  - No event: seg_out and count hold; accept=0, drop=0.
- Invariant: slots 0..count-1 are nonzero and slots count..SLOTS-1 are zero.
  - The downstream backspace stage shifts right and zero-fills on its own copy. Resynchronising count with it is outside this block.
- Widths: count never wraps. It saturates at SLOTS by construction.

Test Plan:
- Reset, then rst high with char_valid held high for 5 cycles -> no accept, seg_out=0, empty=1.
- Append 8'h3F, then 8'h06 (each strobe 3 cycles high, 2 low) -> seg_out=64'h0000_0000_0000_3F06, count=2, exactly two accept pulses.
- Append 8 codes 8'h01..8'h08 -> seg_out=64'h0102_0304_0506_0708, full=1. Then append 8'h09 with OVERWRITE=1 -> seg_out=64'h0203_0405_0607_0809, accept=1 and drop=1 in the same cycle, count=8.
- Same sequence with OVERWRITE=0 -> the 9th event gives drop=1, accept=0, seg_out unchanged at 64'h0102_0304_0506_0708.
- char_in=8'h00 event -> drop=1, count unchanged. clear asserted in the same cycle as an event with count=3 -> seg_out=0, count=0, no accept or drop pulse.
- Assert rst mid-sequence with count=5 -> outputs are 0 immediately, before the next clk edge. After release, the first fresh strobe 8'h5B -> seg_out=64'h5B, count=1.
